// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and default frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: two clk cycles.
// Backpressure: none; the output follows the input continuously.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification, LSB-first data, stop check.
// Latency: rx_valid/frame_err register one sys_clk edge after the mid-stop-bit tick.
// Backpressure: rx_valid/rx_ready handshake; an unconsumed byte is overwritten and flagged by overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic                 byte_done;
    logic                 stop_bad;

    uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (sys_clk),
        .rst_n (reset_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame-tracking state: FSM, oversample counter, bit counter, shift register.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shift_q  <= shift_nxt;
        end
    end

    // Next-state logic; everything only moves on a sample tick.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    // Half a bit in: a line that has gone high again was only a glitch.
                    if (tick_cnt == HALF_LAST) begin
                        if (!rx_s) begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    // Sample one full bit period after the previous centre point.
                    if (tick_cnt == FULL_LAST) begin
                        tick_nxt  = '0;
                        shift_nxt = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_nxt   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a following start edge is never missed.
                    if (tick_cnt == FULL_LAST) begin
                        tick_nxt  = '0;
                        state_nxt = IDLE;
                        if (rx_s) begin
                            byte_done = 1'b1;
                        end else begin
                            stop_bad = 1'b1;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output holding register, valid flag and one-cycle status pulses.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (byte_done) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            frame_err <= stop_bad;
            // A handshake in the completion cycle means the old byte was taken.
            overrun   <= byte_done && rx_valid && !rx_ready;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven at 16 ticks per bit, tick every 4 clocks.
// Latency: n/a.
// Backpressure: rx_ready driven per scenario.
module tb_uart_rx;

    logic       sys_clk     = 1'b0;
    logic       reset_n     = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx          = 1'b1;
    logic       rx_ready    = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Monotonic per-cycle counts of output activity, sampled on the falling edge.
    int vld_cyc = 0;
    int fe_cyc  = 0;
    int ov_cyc  = 0;
    int vld_s, fe_s, ov_s;

    logic [1:0] tick_div = 2'd0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // One tick every fourth clock, changed away from the rising edge.
    always @(negedge sys_clk) begin
        tick_div    = tick_div + 2'd1;
        sample_tick = (tick_div == 2'd0);
    end

    // Count cycles each output is high.
    always @(negedge sys_clk) begin
        if (rx_valid === 1'b1)  vld_cyc = vld_cyc + 1;
        if (frame_err === 1'b1) fe_cyc  = fe_cyc + 1;
        if (overrun === 1'b1)   ov_cyc  = ov_cyc + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic snap();
        vld_s = vld_cyc;
        fe_s  = fe_cyc;
        ov_s  = ov_cyc;
    endtask

    // Returns 1 time unit after the rising edge of the n-th sample tick.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            while (sample_tick !== 1'b1) @(posedge sys_clk);
        end
        #1;
    endtask

    // Must be called just after a tick edge. With coincide set, rx_ready is
    // pulsed for exactly the cycle in which the stop bit is sampled (9th tick).
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit coincide);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        rx = stop_b;
        if (coincide) begin
            wait_ticks(8);
            repeat (3) @(posedge sys_clk);
            #1 rx_ready = 1'b1;
            @(posedge sys_clk);
            #1 rx_ready = 1'b0;
            wait_ticks(7);
        end else begin
            wait_ticks(16);
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge sys_clk);
        reset_n = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_frame_a5();
        rx_ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_ticks(4);
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", rx_data); end
        checks++; if (vld_cyc - vld_s != 1) begin errors++; $display("FAIL a5_valid_cycles: got %0d want 1", vld_cyc - vld_s); end
        checks++; if (fe_cyc - fe_s != 0) begin errors++; $display("FAIL a5_frame_err: got %0d want 0", fe_cyc - fe_s); end
        checks++; if (ov_cyc - ov_s != 0) begin errors++; $display("FAIL a5_overrun: got %0d want 0", ov_cyc - ov_s); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        snap();
        rx = 1'b0;
        wait_ticks(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        rx = 1'b1;
        wait_ticks(12);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b want 0", busy); end
        checks++; if (vld_cyc - vld_s != 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", vld_cyc - vld_s); end
    endtask

    task automatic test_frame_err();
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(20);
        checks++; if (fe_cyc - fe_s != 1) begin errors++; $display("FAIL ferr_pulse_cycles: got %0d want 1", fe_cyc - fe_s); end
        checks++; if (vld_cyc - vld_s != 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", vld_cyc - vld_s); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %h want a5", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b want 0", busy); end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_first: got %h/%b want 11/1", rx_data, rx_valid); end
        send_frame(8'h22, 1'b1, 1'b0);
        wait_ticks(4);
        checks++; if (ov_cyc - ov_s != 1) begin errors++; $display("FAIL ovr_pulse: got %0d want 1", ov_cyc - ov_s); end
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovr_data: got %h want 22", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        rx_ready = 1'b1;
        @(posedge sys_clk);
        #1 rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b want 0", rx_valid); end
        rx_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h22) begin errors++; $display("FAIL ready_no_valid: got %b/%h want 0/22", rx_valid, rx_data); end
        wait_ticks(1);
    endtask

    task automatic test_coincident();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        snap();
        send_frame(8'h22, 1'b1, 1'b1);
        wait_ticks(4);
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL coin_data: got %h want 22", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL coin_valid: got %b want 1", rx_valid); end
        checks++; if (ov_cyc - ov_s != 0) begin errors++; $display("FAIL coin_overrun: got %0d want 0", ov_cyc - ov_s); end
        rx_ready = 1'b1;
        @(posedge sys_clk);
        #1 rx_ready = 1'b0;
        wait_ticks(1);
    endtask

    task automatic test_reset_mid();
        rx_ready = 1'b1;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            wait_ticks(16);
        end
        rx = 1'b1;
        wait_ticks(8);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        reset_n = 1'b0;
        #3;
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_async: got busy %b valid %b data %h want 0 0 00", busy, rx_valid, rx_data); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got %b %b want 0 0", frame_err, overrun); end
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        snap();
        wait_ticks(40);
        checks++; if (vld_cyc - vld_s != 0 || rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_no_partial: got %0d cycles data %h want 0 00", vld_cyc - vld_s, rx_data); end
        snap();
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_ticks(4);
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data: got %h want 5a", rx_data); end
        checks++; if (vld_cyc - vld_s != 1) begin errors++; $display("FAIL rstmid_next_valid: got %0d want 1", vld_cyc - vld_s); end
        checks++; if (fe_cyc - fe_s != 0) begin errors++; $display("FAIL rstmid_next_ferr: got %0d want 0", fe_cyc - fe_s); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_coincident();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
